// File: rtl/aha_reset_req_sequencer_if.sv
// Command and reset-controller signal bundle for aha_reset_req_sequencer.
// master = platform/environment side, slave = the sequencer.
interface aha_reset_req_sequencer_if #(
  parameter int NUM_DOMAINS = 13
);
  localparam int IDX_W = $clog2(NUM_DOMAINS);

  logic                   CMD_VALID;
  logic                   CMD_READY;
  logic [NUM_DOMAINS-1:0] CMD_MASK;
  logic [NUM_DOMAINS-1:0] REQ;
  logic [NUM_DOMAINS-1:0] ACK;
  logic                   BUSY;
  logic                   DONE;
  logic [NUM_DOMAINS-1:0] ERR_MASK;
  logic [IDX_W-1:0]       CUR_IDX;

  modport master (
    output CMD_VALID, CMD_MASK, ACK,
    input  CMD_READY, REQ, BUSY, DONE, ERR_MASK, CUR_IDX
  );

  modport slave (
    input  CMD_VALID, CMD_MASK, ACK,
    output CMD_READY, REQ, BUSY, DONE, ERR_MASK, CUR_IDX
  );
endinterface

// File: rtl/aha_reset_req_sequencer.sv
// Per-domain reset REQ/ACK sequencer, one 4-phase handshake at a time in ascending order; AHA_RESET_SEQ_TIMEOUT_EN enables per-phase timeouts.
// Latency: ACK seen 2 cycles after arrival, DONE 2 cycles after an empty command; backpressure: CMD_READY low from accept until after DONE.
module aha_reset_req_sequencer #(
  parameter int NUM_DOMAINS    = 13,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                         CLK,
  input logic                         RESET,
  aha_reset_req_sequencer_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_DOMAINS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    REQ_HI = 3'd2,
    REQ_LO = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t                 state;
  logic [NUM_DOMAINS-1:0] pending;
  logic [NUM_DOMAINS-1:0] sel_oh;
  logic [NUM_DOMAINS-1:0] req_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   cmd_ready_r;
  logic [IDX_W-1:0]       cur_idx_r;

  logic [NUM_DOMAINS-1:0] ack_meta;
  logic [NUM_DOMAINS-1:0] ack_s;
  logic [NUM_DOMAINS-1:0] low_oh;
  logic [IDX_W-1:0]       low_idx;
  logic                   ack_hit;

  // ACK comes from other clock domains; only ack_s may reach the FSM.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack_meta <= '0;
      ack_s    <= '0;
    end else begin
      ack_meta <= bus.ACK;
      ack_s    <= ack_meta;
    end
  end

  // Two's-complement trick isolates the lowest pending domain.
  assign low_oh  = pending & (~pending + NUM_DOMAINS'(1));
  assign ack_hit = |(ack_s & sel_oh);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDX_W'(i);
    end
  end

`ifdef AHA_RESET_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]            timer;
  logic [NUM_DOMAINS-1:0] err_mask_r;
  logic                   timeout;

  assign timeout      = (timer == TIMEOUT_LAST);
  assign bus.ERR_MASK = err_mask_r;
`else
  logic [15:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
  assign bus.ERR_MASK       = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      pending     <= '0;
      sel_oh      <= '0;
      req_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
      cur_idx_r   <= '0;
`ifdef AHA_RESET_SEQ_TIMEOUT_EN
      timer       <= '0;
      err_mask_r  <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_r <= 1'b1;
          if (bus.CMD_VALID && cmd_ready_r) begin
            pending     <= bus.CMD_MASK;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            state       <= SCAN;
`ifdef AHA_RESET_SEQ_TIMEOUT_EN
            err_mask_r  <= '0;
`endif
          end
        end

        SCAN: begin
          if (pending == '0) begin
            done_r <= 1'b1;
            state  <= FIN;
          end else begin
            cur_idx_r <= low_idx;
            sel_oh    <= low_oh;
            req_r     <= low_oh;
            state     <= REQ_HI;
`ifdef AHA_RESET_SEQ_TIMEOUT_EN
            timer     <= '0;
`endif
          end
        end

        // ACK is tested before timeout so a same-cycle ACK records no error.
        REQ_HI: begin
          if (ack_hit) begin
            req_r <= '0;
            state <= REQ_LO;
`ifdef AHA_RESET_SEQ_TIMEOUT_EN
            timer <= '0;
          end else if (timeout) begin
            err_mask_r <= err_mask_r | sel_oh;
            req_r      <= '0;
            timer      <= '0;
            state      <= REQ_LO;
          end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
`endif
          end
        end

        REQ_LO: begin
          if (!ack_hit) begin
            pending <= pending & ~sel_oh;
            state   <= SCAN;
`ifdef AHA_RESET_SEQ_TIMEOUT_EN
          end else if (timeout) begin
            err_mask_r <= err_mask_r | sel_oh;
            pending    <= pending & ~sel_oh;
            state      <= SCAN;
          end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
`endif
          end
        end

        FIN: begin
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY = cmd_ready_r;
  assign bus.REQ       = req_r;
  assign bus.BUSY      = busy_r;
  assign bus.DONE      = done_r;
  assign bus.CUR_IDX   = cur_idx_r;

endmodule
